// File: rtl/apb_master_bridge_pkg.sv
// Shared types and default widths for the APB requester bridge.
package apb_pkg;

    // Bridge transfer phases; exported on the debug port for checkers.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } apb_state_e;

    localparam int APB_ADDR_W = 8;
    localparam int APB_DATA_W = 32;

    // Width of the wait-state counter: enough to hold TIMEOUT_CYCLES, never below 1.
    function automatic int apb_cnt_width(input int timeout_cycles);
        return (timeout_cycles > 0) ? $clog2(timeout_cycles + 1) : 1;
    endfunction

endpackage

// File: rtl/apb_master_bridge.sv
// APB3 requester: turns a valid/ready command stream into single APB
// transfers and returns one response per command, with a bounded wait on pready.
//
// Handshakes: a beat transfers on a rising clk edge where valid && ready are
// both 1. cmd_ready is only high in IDLE (and never during rst). rsp_valid,
// once raised, stays high with stable rsp_rdata/rsp_err/rsp_timeout until the
// edge where rsp_ready is also 1.
module apb_master_bridge
    import apb_pkg::*;
#(
    parameter int ADDR_WIDTH     = APB_ADDR_W,
    parameter int DATA_WIDTH     = APB_DATA_W,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    // command stream
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    // response stream
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  rsp_timeout,
    // APB requester side
    output logic [ADDR_WIDTH-1:0] paddr,
    output logic                  psel,
    output logic                  penable,
    output logic                  pwrite,
    output logic [DATA_WIDTH-1:0] pwdata,
    input  logic [DATA_WIDTH-1:0] prdata,
    input  logic                  pready,
    input  logic                  pslverr,
    // debug view of the transfer phase
    output apb_state_e            dbg_state
);

    localparam int CNT_W = apb_cnt_width(TIMEOUT_CYCLES);

    apb_state_e            state_q;
    logic [ADDR_WIDTH-1:0] paddr_q;
    logic                  pwrite_q;
    logic [DATA_WIDTH-1:0] pwdata_q;
    logic                  psel_q;
    logic                  penable_q;
    logic                  rsp_valid_q;
    logic [DATA_WIDTH-1:0] rsp_rdata_q;
    logic                  rsp_err_q;
    logic                  rsp_timeout_q;
    logic [CNT_W-1:0]      cnt_q;
    logic [CNT_W-1:0]      cnt_d;
    logic                  timeout_hit;

    // Wait-state counter next value and the "last allowed ACCESS cycle" flag;
    // with TIMEOUT_CYCLES=0 the counter never moves and the flag never fires.
    always_comb begin
        cnt_d       = cnt_q;
        timeout_hit = 1'b0;
        if (TIMEOUT_CYCLES != 0) begin
            cnt_d       = cnt_q + CNT_W'(1);
            timeout_hit = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
        end
    end

    // Transfer FSM with all APB and response outputs registered alongside the state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            paddr_q       <= '0;
            pwrite_q      <= 1'b0;
            pwdata_q      <= '0;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
            cnt_q         <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    // cmd_ready is implied here: state is IDLE and rst is low.
                    if (cmd_valid) begin
                        paddr_q   <= cmd_addr;
                        pwrite_q  <= cmd_write;
                        pwdata_q  <= cmd_write ? cmd_wdata : '0;
                        psel_q    <= 1'b1;
                        penable_q <= 1'b0;
                        cnt_q     <= '0;
                        state_q   <= SETUP;
                    end
                end
                SETUP: begin
                    penable_q <= 1'b1;
                    state_q   <= ACCESS;
                end
                ACCESS: begin
                    if (pready) begin
                        rsp_rdata_q   <= pwrite_q ? '0 : prdata;
                        rsp_err_q     <= pslverr;
                        rsp_timeout_q <= 1'b0;
                        psel_q        <= 1'b0;
                        penable_q     <= 1'b0;
                        rsp_valid_q   <= 1'b1;
                        state_q       <= RESP;
                    end else begin
                        cnt_q <= cnt_d;
                        if (timeout_hit) begin
                            // Slave never answered: release the bus and report an abort.
                            rsp_rdata_q   <= '0;
                            rsp_err_q     <= 1'b1;
                            rsp_timeout_q <= 1'b1;
                            psel_q        <= 1'b0;
                            penable_q     <= 1'b0;
                            rsp_valid_q   <= 1'b1;
                            state_q       <= RESP;
                        end
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    psel_q      <= 1'b0;
                    penable_q   <= 1'b0;
                    rsp_valid_q <= 1'b0;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign cmd_ready   = (state_q == IDLE) && !rst;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_err     = rsp_err_q;
    assign rsp_timeout = rsp_timeout_q;
    assign paddr       = paddr_q;
    assign psel        = psel_q;
    assign penable     = penable_q;
    assign pwrite      = pwrite_q;
    assign pwdata      = pwdata_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Bench for apb_master_bridge: transaction-level expectations expanded into a
// per-cycle expected timeline, checked by one compare process on every negedge.
module tb_apb_master_bridge;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [7:0]  cmd_addr;
  logic [31:0] cmd_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        rsp_timeout;
  logic [7:0]  paddr;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;
  logic [1:0]  dbg_state;

  apb_master_bridge #(
    .ADDR_WIDTH(8),
    .DATA_WIDTH(32),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .paddr(paddr), .psel(psel), .penable(penable), .pwrite(pwrite),
    .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr),
    .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  typedef struct {
    logic        cmd_ready;
    logic        psel;
    logic        penable;
    logic        rsp_valid;
    logic [7:0]  paddr;
    logic        pwrite;
    logic [31:0] pwdata;
    logic [31:0] rdata;
    logic        err;
    logic        tmo;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur;

  int checks = 0;
  int failures = 0;

  // model of the retained bus fields and the pending response
  logic [7:0]  m_addr = '0;
  logic        m_write = 1'b0;
  logic [31:0] m_wdata = '0;
  logic [31:0] m_rdata = '0;
  logic        m_err = 1'b0;
  logic        m_tmo = 1'b0;

  // DUT-observed transaction statistics (for literal checks)
  bit          mon_busy = 1'b0;
  int          mon_lat = 0;
  int          mon_acc = 0;
  int          mon_rsp_lat = 0;
  int          mon_rsp_acc = 0;
  logic [31:0] mon_rdata = '0;
  logic        mon_err = 1'b0;
  logic        mon_tmo = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=0x%0h exp=0x%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic cr, input logic ps, input logic pe, input logic rv);
    exp_t e;
    e.cmd_ready = cr;
    e.psel      = ps;
    e.penable   = pe;
    e.rsp_valid = rv;
    e.paddr     = m_addr;
    e.pwrite    = m_write;
    e.pwdata    = m_wdata;
    e.rdata     = m_rdata;
    e.err       = m_err;
    e.tmo       = m_tmo;
    exp_q.push_back(e);
  endtask

  // ---------------- compare process + monitor ----------------
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      cur = exp_q.pop_front();
      chk("cmd_ready", 32'(cmd_ready), 32'(cur.cmd_ready));
      chk("psel",      32'(psel),      32'(cur.psel));
      chk("penable",   32'(penable),   32'(cur.penable));
      chk("rsp_valid", 32'(rsp_valid), 32'(cur.rsp_valid));
      chk("paddr",     32'(paddr),     32'(cur.paddr));
      chk("pwrite",    32'(pwrite),    32'(cur.pwrite));
      chk("pwdata",    pwdata,         cur.pwdata);
      if (cur.rsp_valid) begin
        chk("rsp_rdata",   rsp_rdata,        cur.rdata);
        chk("rsp_err",     32'(rsp_err),     32'(cur.err));
        chk("rsp_timeout", 32'(rsp_timeout), 32'(cur.tmo));
      end
    end
    if (rst) begin
      mon_busy = 1'b0;
    end else if (cmd_valid && cmd_ready) begin
      mon_busy = 1'b1;
      mon_lat  = 0;
      mon_acc  = 0;
    end else if (mon_busy) begin
      mon_lat++;
      if (psel && penable) mon_acc++;
      if (rsp_valid) begin
        mon_busy    = 1'b0;
        mon_rsp_lat = mon_lat;
        mon_rsp_acc = mon_acc;
        mon_rdata   = rsp_rdata;
        mon_err     = rsp_err;
        mon_tmo     = rsp_timeout;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_cmd();
    cmd_valid = 1'($urandom_range(0, 1));
    cmd_write = 1'($urandom_range(0, 1));
    cmd_addr  = 8'($urandom);
    cmd_wdata = $urandom;
  endtask

  task automatic rand_slave();
    pready  = 1'($urandom_range(0, 1));
    pslverr = 1'($urandom_range(0, 1));
    prdata  = $urandom;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      next_cyc();
      rand_cmd();
      cmd_valid = 1'b0;
      rand_slave();
      rsp_ready = 1'($urandom_range(0, 1));
      push(1'b1, 1'b0, 1'b0, 1'b0);
    end
  endtask

  // One command; waits = ACCESS cycles with pready low before the slave answers.
  task automatic xfer(input logic wr, input logic [7:0] addr, input logic [31:0] wdata,
                      input int waits, input logic slverr, input logic [31:0] rdata,
                      input int rdly);
    logic tmo;
    int   nacc;
    tmo  = (waits >= TO);
    nacc = tmo ? TO : waits + 1;
    next_cyc();
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = addr;
    cmd_wdata = wdata;
    rand_slave();
    rsp_ready = 1'($urandom_range(0, 1));
    push(1'b1, 1'b0, 1'b0, 1'b0);
    m_addr  = addr;
    m_write = wr;
    m_wdata = wr ? wdata : 32'h0;
    next_cyc();
    rand_cmd();
    rand_slave();
    push(1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < nacc; i++) begin
      next_cyc();
      rand_cmd();
      if (!tmo && i == waits) begin
        pready  = 1'b1;
        pslverr = slverr;
        prdata  = rdata;
      end else begin
        pready  = 1'b0;
        pslverr = 1'($urandom_range(0, 1));
        prdata  = $urandom;
      end
      push(1'b0, 1'b1, 1'b1, 1'b0);
    end
    m_rdata = (tmo || wr) ? 32'h0 : rdata;
    m_err   = tmo ? 1'b1 : slverr;
    m_tmo   = tmo;
    for (int j = 0; j <= rdly; j++) begin
      next_cyc();
      rand_cmd();
      rand_slave();
      rsp_ready = (j == rdly);
      push(1'b0, 1'b0, 1'b0, 1'b1);
    end
  endtask

  // Read with pready low; reset lands in the second ACCESS cycle.
  task automatic rst_mid();
    next_cyc();
    cmd_valid = 1'b1;
    cmd_write = 1'b0;
    cmd_addr  = 8'h30;
    cmd_wdata = 32'h11112222;
    pready    = 1'b0;
    rsp_ready = 1'b1;
    push(1'b1, 1'b0, 1'b0, 1'b0);
    m_addr  = 8'h30;
    m_write = 1'b0;
    m_wdata = 32'h0;
    next_cyc();
    cmd_valid = 1'b0;
    push(1'b0, 1'b1, 1'b0, 1'b0);
    next_cyc();
    pready = 1'b0;
    push(1'b0, 1'b1, 1'b1, 1'b0);
    next_cyc();
    pready = 1'b0;
    push(1'b0, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("rstmid_psel_async",      32'(psel),      32'h0);
    chk("rstmid_penable_async",   32'(penable),   32'h0);
    chk("rstmid_rsp_valid_async", 32'(rsp_valid), 32'h0);
    chk("rstmid_cmd_ready",       32'(cmd_ready), 32'h0);
    next_cyc();
    chk("rstmid_paddr", 32'(paddr), 32'h0);
    chk("rstmid_psel",  32'(psel),  32'h0);
    m_addr  = '0;
    m_write = 1'b0;
    m_wdata = '0;
    rst       = 1'b0;
    cmd_valid = 1'b0;
    push(1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = '0;
    cmd_wdata = '0;
    rsp_ready = 1'b0;
    prdata    = '0;
    pready    = 1'b0;
    pslverr   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_cmd_ready",   32'(cmd_ready),   32'h0);
    chk("reset_psel",        32'(psel),        32'h0);
    chk("reset_penable",     32'(penable),     32'h0);
    chk("reset_pwrite",      32'(pwrite),      32'h0);
    chk("reset_rsp_valid",   32'(rsp_valid),   32'h0);
    chk("reset_paddr",       32'(paddr),       32'h0);
    chk("reset_pwdata",      pwdata,           32'h0);
    chk("reset_rsp_rdata",   rsp_rdata,        32'h0);
    chk("reset_rsp_err",     32'(rsp_err),     32'h0);
    chk("reset_rsp_timeout", 32'(rsp_timeout), 32'h0);
    rst = 1'b0;
    push(1'b1, 1'b0, 1'b0, 1'b0);
    idle(1);

    // zero-wait write
    xfer(1'b1, 8'h04, 32'hDEADBEEF, 0, 1'b0, 32'hCAFEF00D, 0);
    idle(1);
    chk("wr_latency",   32'(mon_rsp_lat), 32'd3);
    chk("wr_access",    32'(mon_rsp_acc), 32'd1);
    chk("wr_rsp_rdata", mon_rdata,        32'h0);
    chk("wr_rsp_err",   32'(mon_err),     32'h0);

    // read with 3 wait states
    xfer(1'b0, 8'h08, 32'h0, 3, 1'b0, 32'h12345678, 0);
    idle(1);
    chk("rd_wait_access", 32'(mon_rsp_acc), 32'd4);
    chk("rd_wait_rdata",  mon_rdata,        32'h12345678);
    chk("rd_wait_err",    32'(mon_err),     32'h0);

    // slave error on a read
    xfer(1'b0, 8'h0C, 32'h0, 0, 1'b1, 32'hA5A5A5A5, 0);
    idle(1);
    chk("slverr_err",   32'(mon_err),   32'h1);
    chk("slverr_tmo",   32'(mon_tmo),   32'h0);
    chk("slverr_rdata", mon_rdata,      32'hA5A5A5A5);

    // slave never ready
    xfer(1'b0, 8'h10, 32'h0, 40, 1'b0, 32'h55AA55AA, 0);
    idle(1);
    chk("tmo_access", 32'(mon_rsp_acc), 32'd16);
    chk("tmo_err",    32'(mon_err),     32'h1);
    chk("tmo_flag",   32'(mon_tmo),     32'h1);
    chk("tmo_rdata",  mon_rdata,        32'h0);

    // last wait state before the timeout still completes normally
    xfer(1'b0, 8'h14, 32'h0, 15, 1'b0, 32'h0BADF00D, 0);
    idle(1);
    chk("edge_access", 32'(mon_rsp_acc), 32'd16);
    chk("edge_tmo",    32'(mon_tmo),     32'h0);
    chk("edge_rdata",  mon_rdata,        32'h0BADF00D);

    // stalled response consumer
    xfer(1'b1, 8'h20, 32'h87654321, 1, 1'b0, 32'h0, 5);
    idle(2);

    // reset in the middle of a transfer, then normal traffic
    rst_mid();
    xfer(1'b0, 8'h24, 32'h0, 0, 1'b0, 32'h600DCAFE, 0);
    idle(1);
    chk("post_rst_rdata", mon_rdata, 32'h600DCAFE);

    // randomized traffic
    for (int n = 0; n < 150; n++) begin
      xfer(1'($urandom_range(0, 1)), 8'($urandom), $urandom,
           ($urandom_range(0, 9) == 0) ? int'($urandom_range(16, 20)) : int'($urandom_range(0, 4)),
           1'($urandom_range(0, 3) == 0), $urandom, int'($urandom_range(0, 3)));
      idle(int'($urandom_range(0, 2)));
    end

    idle(2);
    @(negedge clk);
    #1;
    chk("exp_queue_drained", 32'(exp_q.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time limit so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog act=timeout exp=finish");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
